// File: rtl/div_scheduler.sv
// div_scheduler: round-robin scheduler sharing one pipelined signed divider among NREQ requesters.
// Optional DIV_ZERO_CHECK_EN: Den==0 ops return Coc='1, Res=Num and pulse RspDivZero.
module div_scheduler #(
   parameter int tamanyo = 32,
   parameter int NREQ    = 4,
   parameter int LATENCY = 33
) (
   input  logic                    CLK,
   input  logic                    RSTa,
   input  logic                    Enable,
   input  logic [NREQ-1:0]         ReqValid,
   output logic [NREQ-1:0]         ReqReady,
   input  logic [NREQ*tamanyo-1:0] ReqNum,
   input  logic [NREQ*tamanyo-1:0] ReqDen,
   output logic                    DivStart,
   output logic [tamanyo-1:0]      DivNum,
   output logic [tamanyo-1:0]      DivDen,
   input  logic                    DivDone,
   input  logic [tamanyo-1:0]      DivCoc,
   input  logic [tamanyo-1:0]      DivRes,
   output logic                    RspValid,
   output logic [$clog2(NREQ)-1:0] RspId,
   output logic [tamanyo-1:0]      RspCoc,
   output logic [tamanyo-1:0]      RspRes,
   output logic                    Busy,
`ifdef DIV_ZERO_CHECK_EN
   output logic                    RspDivZero,
`endif
   output logic                    SeqErr
);
   localparam int IDW = $clog2(NREQ);

   typedef struct packed {
      logic               valid;
      logic [IDW-1:0]     id;
`ifdef DIV_ZERO_CHECK_EN
      logic               zero;
      logic [tamanyo-1:0] num;
`endif
   } tag_t;

   logic [IDW-1:0]     ptr;
   logic [IDW-1:0]     idx;
   logic [IDW-1:0]     grant_id;
   logic [IDW-1:0]     start_id;
   logic               found;
   logic [tamanyo-1:0] sel_num;
   logic [tamanyo-1:0] sel_den;
   tag_t [LATENCY-1:0] tag_pipe;
   tag_t               tag_in;
   tag_t               tag_out;
   logic [LATENCY-1:0] tag_valids;
`ifdef DIV_ZERO_CHECK_EN
   logic               start_zero;
`endif

   // Scan ptr+1, ptr+2, ... so the last winner has lowest priority next time.
   // NOTE: every output of this block gets a default first, so no latch is inferred.
   always_comb begin
      ReqReady = '0;
      grant_id = '0;
      idx      = '0;
      found    = 1'b0;
      sel_num  = '0;
      sel_den  = '0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = IDW'((int'(ptr) + k) % NREQ);
         if (Enable && !found && ReqValid[idx]) begin
            found         = 1'b1;
            grant_id      = idx;
            ReqReady[idx] = 1'b1;
            sel_num       = ReqNum[int'(idx)*tamanyo +: tamanyo];
            sel_den       = ReqDen[int'(idx)*tamanyo +: tamanyo];
         end
      end
   end

   always_comb begin
      tag_in       = '0;
      tag_in.valid = DivStart;
      tag_in.id    = start_id;
`ifdef DIV_ZERO_CHECK_EN
      tag_in.zero  = start_zero;
      tag_in.num   = DivNum;
`endif
   end

   always_comb begin
      tag_valids = '0;
      for (int i = 0; i < LATENCY; i++) tag_valids[i] = tag_pipe[i].valid;
   end

   assign tag_out = tag_pipe[LATENCY-1];
   assign Busy    = DivStart | (|tag_valids) | RspValid;

   // NOTE: the tag pipe is reset because its valid bits alone decide whether a response is produced.
   always_ff @(posedge CLK or negedge RSTa) begin
      if (!RSTa) begin
         ptr      <= IDW'(NREQ - 1);
         DivStart <= 1'b0;
         DivNum   <= '0;
         DivDen   <= '0;
         start_id <= '0;
         tag_pipe <= '0;
         RspValid <= 1'b0;
         RspId    <= '0;
         RspCoc   <= '0;
         RspRes   <= '0;
         SeqErr   <= 1'b0;
`ifdef DIV_ZERO_CHECK_EN
         start_zero <= 1'b0;
         RspDivZero <= 1'b0;
`endif
      end else begin
         DivStart <= found;
         if (found) begin
            ptr      <= grant_id;
            start_id <= grant_id;
            DivNum   <= sel_num;
            DivDen   <= sel_den;
`ifdef DIV_ZERO_CHECK_EN
            start_zero <= (sel_den == '0);
`endif
         end
         tag_pipe <= {tag_pipe[LATENCY-2:0], tag_in};
         if (DivDone != tag_out.valid) SeqErr <= 1'b1;
         RspValid <= tag_out.valid;
`ifdef DIV_ZERO_CHECK_EN
         RspDivZero <= tag_out.valid & tag_out.zero;
`endif
         if (tag_out.valid) begin
            RspId <= tag_out.id;
`ifdef DIV_ZERO_CHECK_EN
            RspCoc <= tag_out.zero ? '1 : DivCoc;
            RspRes <= tag_out.zero ? tag_out.num : DivRes;
`else
            RspCoc <= DivCoc;
            RspRes <= DivRes;
`endif
         end
      end
   end
endmodule

// File: tb/tb_div_scheduler.sv
// Testbench for div_scheduler: behavioural divider, response scoreboard and round-robin model.
module tb_div_scheduler;
   localparam int W       = 32;
   localparam int NREQ    = 4;
   localparam int LATENCY = 33;

   logic              CLK, RSTa, Enable;
   logic [NREQ-1:0]   ReqValid, ReqReady;
   logic [NREQ*W-1:0] ReqNum, ReqDen;
   logic              DivStart, DivDone;
   logic [W-1:0]      DivNum, DivDen, DivCoc, DivRes;
   logic              RspValid, Busy, SeqErr;
   logic [1:0]        RspId;
   logic [W-1:0]      RspCoc, RspRes;
`ifdef DIV_ZERO_CHECK_EN
   logic              RspDivZero;
`endif

   div_scheduler #(.tamanyo(W), .NREQ(NREQ), .LATENCY(LATENCY)) dut (
      .CLK(CLK), .RSTa(RSTa), .Enable(Enable), .ReqValid(ReqValid), .ReqReady(ReqReady),
      .ReqNum(ReqNum), .ReqDen(ReqDen), .DivStart(DivStart), .DivNum(DivNum), .DivDen(DivDen),
      .DivDone(DivDone), .DivCoc(DivCoc), .DivRes(DivRes), .RspValid(RspValid), .RspId(RspId),
      .RspCoc(RspCoc), .RspRes(RspRes), .Busy(Busy),
`ifdef DIV_ZERO_CHECK_EN
      .RspDivZero(RspDivZero),
`endif
      .SeqErr(SeqErr)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic logic [W-1:0] sdiv(input logic [W-1:0] n, input logic [W-1:0] d, input bit rem);
      logic signed [W-1:0] sn, sd;
      sn = n;
      sd = d;
      if (sd == 0) return '0;
      return rem ? sn % sd : sn / sd;
   endfunction

   // Fixed-latency divider: Done is high LATENCY cycles after Start is sampled.
   logic [LATENCY-1:0] dv_v;
   logic [W-1:0]       dv_q [LATENCY];
   logic [W-1:0]       dv_r [LATENCY];
   bit                 kill_done;

   always @(posedge CLK or negedge RSTa) begin
      if (!RSTa) dv_v <= '0;
      else begin
         dv_v    <= {dv_v[LATENCY-2:0], DivStart};
         dv_q[0] <= sdiv(DivNum, DivDen, 1'b0);
         dv_r[0] <= sdiv(DivNum, DivDen, 1'b1);
         for (int i = 1; i < LATENCY; i++) begin
            dv_q[i] <= dv_q[i-1];
            dv_r[i] <= dv_r[i-1];
         end
      end
   end
   assign DivDone = dv_v[LATENCY-1] & ~kill_done;
   assign DivCoc  = dv_q[LATENCY-1];
   assign DivRes  = dv_r[LATENCY-1];

   typedef struct {
      int           id;
      logic [W-1:0] coc;
      logic [W-1:0] res;
      bit           dz;
      int           due;
   } exp_t;

   exp_t         exp_q[$];
   int           rsp_log[$];
   int           grant_log[$];
   int           n_checks, n_errors, cyc, model_ptr, last_grant, last_id;
   bit           started_prev, seq_err_exp, last_dz;
   logic [W-1:0] last_coc, last_res, ex;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // One clock cycle: compare against the model at negedge+1, then advance.
   task automatic step();
      int              g, idx;
      exp_t            e;
      logic [W-1:0]    n, d;
      logic [NREQ-1:0] rdy_exp;
      #1;
      g = -1;
      if (Enable) begin
         for (int k = 1; k <= NREQ; k++) begin
            idx = (model_ptr + k) % NREQ;
            if (g < 0 && ReqValid[idx]) g = idx;
         end
      end
      rdy_exp = '0;
      if (g >= 0) rdy_exp[g] = 1'b1;
      check("ready", ReqReady, rdy_exp);
      last_grant = -1;
      for (int i = 0; i < NREQ; i++) if (ReqReady[i]) last_grant = i;
      check("busy", Busy, exp_q.size() != 0);
      check("div_start", DivStart, started_prev);
      check("seq_err", SeqErr, seq_err_exp);
      if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
         e = exp_q.pop_front();
         check("rsp_valid", RspValid, 1'b1);
         check("rsp_id", RspId, e.id);
         check("rsp_coc", RspCoc, e.coc);
         check("rsp_res", RspRes, e.res);
`ifdef DIV_ZERO_CHECK_EN
         check("rsp_dz", RspDivZero, e.dz);
         last_dz = RspDivZero;
`endif
         rsp_log.push_back(int'(RspId));
         last_id  = int'(RspId);
         last_coc = RspCoc;
         last_res = RspRes;
      end else begin
         check("rsp_valid", RspValid, 1'b0);
`ifdef DIV_ZERO_CHECK_EN
         check("rsp_dz", RspDivZero, 1'b0);
`endif
      end
      if (kill_done && exp_q.size() != 0 && exp_q[0].due == cyc + 1) seq_err_exp = 1'b1;
      if (g >= 0) begin
         n     = ReqNum[g*W +: W];
         d     = ReqDen[g*W +: W];
         e.id  = g;
         e.due = cyc + LATENCY + 2;
         e.coc = sdiv(n, d, 1'b0);
         e.res = sdiv(n, d, 1'b1);
         e.dz  = 1'b0;
`ifdef DIV_ZERO_CHECK_EN
         if (d == '0) begin
            e.coc = '1;
            e.res = n;
            e.dz  = 1'b1;
         end
`endif
         exp_q.push_back(e);
         model_ptr = g;
      end
      started_prev = (g >= 0);
      @(posedge CLK);
      @(negedge CLK);
      cyc++;
   endtask

   task automatic do_reset();
      RSTa     = 1'b0;
      ReqValid = '0;
      #1;
      check("rst_rsp_valid", RspValid, 1'b0);
      check("rst_busy", Busy, 1'b0);
      check("rst_seq_err", SeqErr, 1'b0);
      check("rst_div_start", DivStart, 1'b0);
      check("rst_div_num", DivNum, '0);
      check("rst_div_den", DivDen, '0);
      check("rst_rsp_id", RspId, '0);
      check("rst_rsp_coc", RspCoc, '0);
      check("rst_rsp_res", RspRes, '0);
      check("rst_ready", ReqReady, '0);
`ifdef DIV_ZERO_CHECK_EN
      check("rst_rsp_dz", RspDivZero, 1'b0);
`endif
      exp_q.delete();
      model_ptr    = NREQ - 1;
      started_prev = 1'b0;
      seq_err_exp  = 1'b0;
      @(negedge CLK);
      RSTa = 1'b1;
      cyc++;
   endtask

   task automatic issue(input int id, input logic [W-1:0] n, input logic [W-1:0] d);
      ReqValid         = '0;
      ReqValid[id]     = 1'b1;
      ReqNum[id*W +: W] = n;
      ReqDen[id*W +: W] = d;
      last_id  = -1;
      last_coc = 32'hDEAD_BEEF;
      last_res = 32'hDEAD_BEEF;
      step();
      ReqValid = '0;
   endtask

   task automatic idle(input int n);
      ReqValid = '0;
      repeat (n) step();
   endtask

   task automatic rand_operands();
      logic [W-1:0] d;
      for (int i = 0; i < NREQ; i++) begin
         ReqNum[i*W +: W] = $urandom;
         d = W'($urandom_range(2000, 0)) - 32'd1000;
         if (d == '0) d = 32'd1;
         if (d == '1 && ReqNum[i*W +: W] == 32'h8000_0000) d = 32'd1;
         ReqDen[i*W +: W] = d;
      end
   endtask

   initial begin
      RSTa = 1'b0; Enable = 1'b1; ReqValid = '0; ReqNum = '0; ReqDen = '0;
      kill_done = 1'b0; n_checks = 0; n_errors = 0; cyc = 0; last_dz = 1'b0;
      @(negedge CLK);
      do_reset();

      issue(0, 100, 7);
      idle(LATENCY + 4);
      check("single_id", last_id, 0);
      check("single_coc", last_coc, 32'd14);
      check("single_res", last_res, 32'd2);

      issue(2, -100, 7);
      idle(LATENCY + 4);
      ex = -14;
      check("neg_num_coc", last_coc, ex);
      ex = -2;
      check("neg_num_res", last_res, ex);
      check("neg_num_id", last_id, 2);
      issue(2, 100, -7);
      idle(LATENCY + 4);
      ex = -14;
      check("neg_den_coc", last_coc, ex);
      check("neg_den_res", last_res, 32'd2);

      // Contention from reset, then Enable drops with all requesters still pending.
      do_reset();
      grant_log.delete();
      rsp_log.delete();
      rand_operands();
      ReqValid = '1;
      repeat (8) begin
         step();
         grant_log.push_back(last_grant);
      end
      Enable = 1'b0;
      repeat (LATENCY + 4) step();
      check("cont_rsp_count", rsp_log.size(), 8);
      for (int i = 0; i < 8; i++) begin
         check("cont_grant_order", grant_log[i], i % NREQ);
         if (i < rsp_log.size()) check("cont_rsp_order", rsp_log[i], i % NREQ);
      end
      check("disabled_busy", Busy, 1'b0);
      Enable = 1'b1;

      repeat (300) begin
         Enable   = ($urandom_range(9, 0) != 0);
         ReqValid = NREQ'($urandom);
         rand_operands();
         step();
      end
      Enable = 1'b1;
      idle(LATENCY + 4);

      // Reset with five operations in flight.
      rand_operands();
      ReqValid = '1;
      repeat (5) step();
      idle(3);
      do_reset();
      idle(LATENCY + 5);
      ReqValid = '1;
      step();
      check("rst_first_grant", last_grant, 0);
      idle(LATENCY + 4);

`ifdef DIV_ZERO_CHECK_EN
      issue(1, 55, 0);
      idle(LATENCY + 4);
      check("dz_coc", last_coc, 32'hFFFF_FFFF);
      check("dz_res", last_res, 32'd55);
      check("dz_flag", last_dz, 1'b1);
`endif

      kill_done = 1'b1;
      issue(3, 1000, 10);
      idle(LATENCY + 4);
      check("seq_err_set", SeqErr, 1'b1);
      check("seq_err_rsp_id", last_id, 3);
      kill_done = 1'b0;
      do_reset();
      idle(3);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
